// File: rtl/lfsr_rng_if.sv
// Request/seed/result bundle between the sequence generator and the LFSR random source.
interface lfsr_rng_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OUT_W = 4
);
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] num;

    modport master (
        output seed_load, seed_in, req,
        input  busy, valid, num
    );

    modport slave (
        input  seed_load, seed_in, req,
        output busy, valid, num
    );
endinterface

// File: rtl/lfsr_rng.sv
// Free-running LFSR with reseed, plus a req/valid draw of an unbiased value in [0, RANGE)
// by rejection sampling with a bounded retry count and a folded fallback.
module lfsr_rng #(
    parameter int unsigned WIDTH     = 64,
    parameter logic [63:0] TAPS      = 64'hD800000000000000,
    parameter logic [63:0] SEED      = 64'd2854292432761329182,
    parameter bit          GALOIS    = 1'b0,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned RANGE     = 16,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic       clock,
    input  logic       reset,
    lfsr_rng_if.slave  bus
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned CW    = OUT_W + 1;
    localparam logic [WIDTH-1:0] TAPS_W  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
    localparam logic [CW-1:0]    RANGE_V = CW'(RANGE);
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

    typedef enum logic {IDLE, DRAW} state_t;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_step;

    state_t           state, state_next;
    logic [TRY_W-1:0] tries, tries_next;
    logic             busy_next, valid_next;
    logic [OUT_W-1:0] num_next;
    logic [CW-1:0]    cand;

    // One LFSR step in the selected topology
    generate
        if (GALOIS) begin : g_galois
            always_comb q_step = (q >> 1) ^ (q[0] ? TAPS_W : '0);
        end else begin : g_fib
            always_comb q_step = {q[WIDTH-2:0], ^(q & TAPS_W)};
        end
    endgenerate

    // A zero reseed falls back to SEED so the register can never lock up
    always_ff @(posedge clock) begin
        if (reset)
            q <= SEED_W;
        else if (bus.seed_load)
            q <= (bus.seed_in == '0) ? SEED_W : bus.seed_in;
        else
            q <= q_step;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tries     <= '0;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
            bus.num   <= '0;
        end else begin
            state     <= state_next;
            tries     <= tries_next;
            bus.busy  <= busy_next;
            bus.valid <= valid_next;
            bus.num   <= num_next;
        end
    end

    assign cand = {1'b0, q[OUT_W-1:0]};

    // Draw FSM: candidate is the low OUT_W bits of the state in each DRAW cycle
    always_comb begin
        state_next = state;
        tries_next = tries;
        valid_next = 1'b0;
        num_next   = bus.num;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    state_next = DRAW;
                    tries_next = TRY_W'(1);
                end
            end
            DRAW: begin
                if (cand < RANGE_V) begin
                    num_next   = OUT_W'(cand);
                    valid_next = 1'b1;
                    state_next = IDLE;
                end else if (tries == TRIES_MAX) begin
                    // RANGE > 2^(OUT_W-1) keeps the folded value inside [0, RANGE)
                    num_next   = OUT_W'(cand - RANGE_V);
                    valid_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    tries_next = tries + TRY_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == DRAW);
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: two instances (MAX_TRIES 8 and 2) share directed stimulus; a monitor
// pops per-instance scoreboards on every valid pulse.
module tb_lfsr_rng;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    lfsr_rng_if #(.WIDTH(8), .OUT_W(4)) ia ();
    lfsr_rng_if #(.WIDTH(8), .OUT_W(4)) ib ();

    lfsr_rng #(.WIDTH(8), .TAPS(64'hB8), .SEED(64'h01), .GALOIS(1'b0),
               .OUT_W(4), .RANGE(10), .MAX_TRIES(8))
        dut_a (.clock(clock), .reset(reset), .bus(ia.slave));

    lfsr_rng #(.WIDTH(8), .TAPS(64'hB8), .SEED(64'h01), .GALOIS(1'b0),
               .OUT_W(4), .RANGE(10), .MAX_TRIES(2))
        dut_b (.clock(clock), .reset(reset), .bus(ib.slave));

    typedef struct {
        int         cyc;
        logic [3:0] num;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every valid must match the oldest expectation, both in value and in cycle
    always @(negedge clock) begin
        exp_t e;
        if (ia.valid) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid_a: cycle %0d num %0h, expected no valid", cyc, ia.num);
            end else begin
                e = qa.pop_front();
                chk("valid_cycle_a", 64'(cyc), 64'(e.cyc));
                chk("num_a", 64'(ia.num), 64'(e.num));
            end
        end
        if (ib.valid) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid_b: cycle %0d num %0h, expected no valid", cyc, ib.num);
            end else begin
                e = qb.pop_front();
                chk("valid_cycle_b", 64'(cyc), 64'(e.cyc));
                chk("num_b", 64'(ib.num), 64'(e.num));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the bench in cycle 0 with reset low and q = SEED
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_req(input logic v);
        ia.req = v;
        ib.req = v;
    endtask

    task automatic set_seed(input logic ld, input logic [7:0] s);
        ia.seed_load = ld; ia.seed_in = s;
        ib.seed_load = ld; ib.seed_in = s;
    endtask

    logic [7:0] seq [9];
    bit         seen [256];
    int         dups;

    initial begin
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
        set_req(1'b0);
        set_seed(1'b0, 8'h00);

        // Reset state and the free-running sequence
        do_reset();
        chk("reset_busy", 64'(ia.busy), 64'd0);
        chk("reset_valid", 64'(ia.valid), 64'd0);
        chk("reset_num", 64'(ia.num), 64'd0);
        chk("reset_tries", 64'(dut_a.tries), 64'd0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("seq_q%0d", i), 64'(dut_a.q), 64'(seq[i]));
            step();
        end
        do_reset();
        dups = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 255; i++) begin
            if (seen[dut_a.q]) dups++;
            seen[dut_a.q] = 1'b1;
            step();
        end
        chk("period_no_repeat", 64'(dups), 64'd0);
        chk("period_return", 64'(dut_a.q), 64'h01);

        // Fast accept; req held into the busy cycle must be ignored
        do_reset();
        set_req(1'b1);
        qa.push_back('{2, 4'h2});
        qb.push_back('{2, 4'h2});
        step();
        chk("fast_busy1", 64'(ia.busy), 64'd1);
        step();
        set_req(1'b0);
        chk("fast_busy2", 64'(ia.busy), 64'd0);
        step(); step(); step();

        // Rejections (A) and forced fallback (B), with a req pulse while busy
        do_reset();
        goto_cycle(6);
        set_req(1'b1);
        qa.push_back('{10, 4'h8});
        qb.push_back('{9, 4'h2});
        step();
        set_req(1'b0);
        chk("rej_busy7", 64'(ia.busy), 64'd1);
        goto_cycle(8);
        set_req(1'b1);
        step();
        set_req(1'b0);
        chk("rej_busy9_a", 64'(ia.busy), 64'd1);
        chk("fb_busy9_b", 64'(ib.busy), 64'd0);
        step();
        chk("rej_busy10_a", 64'(ia.busy), 64'd0);
        step(); step(); step();

        // Reseed: zero falls back to SEED, nonzero loads directly, then stepping resumes
        set_seed(1'b1, 8'h00);
        step();
        set_seed(1'b0, 8'h00);
        chk("seed_zero_a", 64'(dut_a.q), 64'h01);
        chk("seed_zero_b", 64'(dut_b.q), 64'h01);
        set_seed(1'b1, 8'h5A);
        step();
        set_seed(1'b0, 8'h00);
        chk("seed_5a", 64'(dut_a.q), 64'h5A);
        step();
        chk("seed_5a_step", 64'(dut_a.q), 64'hB4);

        // Reset in the middle of a draw aborts it without a valid pulse
        do_reset();
        goto_cycle(6);
        set_req(1'b1);
        step();
        set_req(1'b0);
        goto_cycle(8);
        chk("abort_busy_before", 64'(ia.busy), 64'd1);
        reset = 1'b1;
        step();
        chk("abort_busy_a", 64'(ia.busy), 64'd0);
        chk("abort_num_a", 64'(ia.num), 64'd0);
        chk("abort_num_b", 64'(ib.num), 64'd0);
        chk("abort_busy_b", 64'(ib.busy), 64'd0);
        chk("abort_q", 64'(dut_a.q), 64'h01);
        reset = 1'b0;
        step(); step(); step(); step();

        chk("pending_a", 64'(qa.size()), 64'd0);
        chk("pending_b", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
